// File: rtl/tank_level_emulator_if.sv
// Valve-command and level-sensor bundle between the irrigation controller (master)
// and the tank plant model (slave).
interface tank_level_emulator_if #(
  parameter int LEVEL_W = 8
);
  logic               Ve;
  logic               Vs;
  logic               Bs;
  logic [1:0]         fault_sel;
  logic               H;
  logic               M;
  logic               L;
  logic [LEVEL_W-1:0] level;
  logic               tick;
  logic               overflow;
  logic               dry;
  logic [1:0]         phase;

  modport master (
    output Ve, Vs, Bs, fault_sel,
    input  H, M, L, level, tick, overflow, dry, phase
  );

  modport slave (
    input  Ve, Vs, Bs, fault_sel,
    output H, M, L, level, tick, overflow, dry, phase
  );
endinterface

// File: rtl/tank_level_emulator.sv
// Irrigation tank plant model: integrates valve flows on a prescaled tick and thresholds
// the volume into H/M/L sensors with fault injection. Optional macro: SENSOR_DEBOUNCE_EN.
module tank_level_emulator #(
  parameter int LEVEL_W    = 8,
  parameter int CAP        = 200,
  parameter int INIT_LEVEL = 50,
  parameter int L_TH       = 20,
  parameter int M_TH       = 100,
  parameter int H_TH       = 180,
  parameter int FILL_RATE  = 4,
  parameter int DRIP_RATE  = 1,
  parameter int SPRAY_RATE = 3,
  parameter int TICK_DIV   = 50000
) (
  input logic                  clk,
  input logic                  rst,
  tank_level_emulator_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int NW = LEVEL_W + 2;
  localparam logic signed [NW-1:0] FILL_S  = NW'(FILL_RATE);
  localparam logic signed [NW-1:0] DRIP_S  = NW'(DRIP_RATE);
  localparam logic signed [NW-1:0] SPRAY_S = NW'(SPRAY_RATE);
  localparam logic signed [NW-1:0] CAP_S   = NW'(CAP);

  typedef enum logic [1:0] {
    PH_IDLE     = 2'b00,
    PH_FILLING  = 2'b01,
    PH_DRAINING = 2'b10,
    PH_FULL     = 2'b11
  } phase_e;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               ovf_q, ovf_d, dry_q, dry_d;
  phase_e             phase_q, phase_d;
  logic [2:0]         sens_q, sens_d;   // {H, M, L}
  logic [2:0]         raw, deb;
  logic signed [NW-1:0] delta, next_vol;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tick_d = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d  = tick_d ? '0 : cnt_q + CW'(1);

    delta = '0;
    if (bus.Ve) delta = delta + FILL_S;
    if (bus.Vs) delta = delta - DRIP_S;
    if (bus.Bs) delta = delta - SPRAY_S;
    next_vol = $signed({2'b00, level_q}) + delta;

    level_d = level_q;
    ovf_d   = ovf_q;
    dry_d   = dry_q;
    phase_d = phase_q;
    if (tick_q) begin
      if (next_vol > CAP_S) begin
        level_d = LEVEL_W'(CAP);
        if (bus.Ve) ovf_d = 1'b1;
      end else if (next_vol[NW-1]) begin
        level_d = '0;
        if (bus.Vs || bus.Bs) dry_d = 1'b1;
      end else begin
        level_d = next_vol[LEVEL_W-1:0];
      end

      // Phase reflects the post-saturation level, then the sign of the requested flow.
      if (level_d == LEVEL_W'(CAP))  phase_d = PH_FULL;
      else if (delta[NW-1])          phase_d = PH_DRAINING;
      else if (delta != '0)          phase_d = PH_FILLING;
      else                           phase_d = PH_IDLE;
    end
  end

  assign raw = {level_q >= LEVEL_W'(H_TH), level_q >= LEVEL_W'(M_TH), level_q >= LEVEL_W'(L_TH)};

`ifdef SENSOR_DEBOUNCE_EN
  logic [2:0]      stab_q, stab_d;
  logic [2:0][1:0] dcnt_q, dcnt_d;

  // A raw value must disagree with the stable value on three consecutive ticks to be adopted.
  always_comb begin
    stab_d = stab_q;
    dcnt_d = dcnt_q;
    for (int k = 0; k < 3; k++) begin
      if (raw[k] == stab_q[k]) begin
        dcnt_d[k] = '0;
      end else if (tick_q) begin
        if (dcnt_q[k] == 2'd2) begin
          stab_d[k] = raw[k];
          dcnt_d[k] = '0;
        end else begin
          dcnt_d[k] = dcnt_q[k] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_q <= '0;
      dcnt_q <= '0;
    end else begin
      stab_q <= stab_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign deb = stab_d;
`else
  assign deb = raw;
`endif

  // Fault overrides act after thresholding and do not wait for a tick.
  always_comb begin
    sens_d    = deb;
    sens_d[2] = deb[2] | (bus.fault_sel == 2'b11);
    sens_d[1] = deb[1] & (bus.fault_sel != 2'b01);
    sens_d[0] = deb[0] & (bus.fault_sel != 2'b10);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      level_q <= LEVEL_W'(INIT_LEVEL);
      ovf_q   <= 1'b0;
      dry_q   <= 1'b0;
      phase_q <= PH_IDLE;
      sens_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      dry_q   <= dry_d;
      phase_q <= phase_d;
      sens_q  <= sens_d;
    end
  end

  assign bus.level    = level_q;
  assign bus.tick     = tick_q;
  assign bus.overflow = ovf_q;
  assign bus.dry      = dry_q;
  assign bus.phase    = phase_q;
  assign bus.H        = sens_q[2];
  assign bus.M        = sens_q[1];
  assign bus.L        = sens_q[0];
endmodule
